// File: rtl/tt_mpu_opacc_pipe.sv
// Pipelined outer-product matrix unit: NUM_MREGS tiles of vl x vl accumulators with OPACC/CIN/COUT.
// Optional MZERO instruction (funct3=3) is enabled by defining TT_MPU_MZERO_EN.
module tt_mpu_opacc_pipe #(
  parameter int VLEN          = 256,
  parameter int XLEN          = 64,
  parameter int NUM_MREGS     = 2,
  parameter int LQ_DEPTH_LOG2 = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_inst,
  input  logic [LQ_DEPTH_LOG2-1:0] i_lqid,
  input  logic [VLEN-1:0]          i_va,
  input  logic [VLEN-1:0]          i_vb,
  input  logic [VLEN-1:0]          i_vc,
  output logic                     o_busy,
  output logic                     o_mvex_lqvld,
  output logic [VLEN-1:0]          o_mvex_lqdata,
  output logic                     o_mvex_lqexc,
  output logic [LQ_DEPTH_LOG2-1:0] o_mvex_lqid
);

  localparam int VL = VLEN / XLEN;
  localparam int PW = 2 * XLEN;
  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
`ifdef TT_MPU_MZERO_EN
  localparam bit MZERO_EN = 1'b1;
`else
  localparam bit MZERO_EN = 1'b0;
`endif

  // Only the low XLEN bits of the product are kept, so signedness does not matter.
  function automatic logic [XLEN-1:0] mul_lo(input logic signed [XLEN-1:0] a,
                                             input logic signed [XLEN-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return p[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] acc_wrap(input logic [XLEN-1:0] acc,
                                               input logic [XLEN-1:0] add);
    return acc + add;
  endfunction

  function automatic logic idx_hit(input logic [4:0] sel, input int idx);
    return {27'd0, sel} == 32'(idx);
  endfunction

  logic [XLEN-1:0] tile [NUM_MREGS][VL][VL];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  mreg, row;
  logic        opc_ok, mreg_ok, row_ok;
  logic        op_opacc, op_cin, op_cout, op_mzero, legal;
  logic        hazard, accept;
  logic [VLEN-1:0] cout_row;
  logic        unused_inst;

  logic            vld_p1, vld_p2;
  logic [4:0]      mreg_p1, mreg_p2;
  logic [XLEN-1:0] prod_p1 [VL][VL];
  logic [XLEN-1:0] prod_p2 [VL][VL];

  assign opcode      = i_inst[6:0];
  assign mreg        = i_inst[11:7];
  assign funct3      = i_inst[14:12];
  assign row         = i_inst[19:15];
  assign unused_inst = ^i_inst[31:20];

  assign opc_ok  = (opcode == OPC_CUSTOM0);
  assign mreg_ok = ({27'd0, mreg} < 32'(NUM_MREGS));
  assign row_ok  = ({27'd0, row} < 32'(VL));

  assign op_opacc = opc_ok && (funct3 == 3'd0) && mreg_ok;
  assign op_cin   = opc_ok && (funct3 == 3'd1) && mreg_ok && row_ok;
  assign op_cout  = opc_ok && (funct3 == 3'd2) && mreg_ok && row_ok;
  assign op_mzero = MZERO_EN && opc_ok && (funct3 == 3'd3) && mreg_ok;
  assign legal    = op_opacc || op_cin || op_cout || op_mzero;

  // Tile moves wait until no OPACC to the same tile is still in flight.
  assign hazard = i_valid && (op_cin || op_cout || op_mzero) &&
                  ((vld_p1 && (mreg_p1 == mreg)) || (vld_p2 && (mreg_p2 == mreg)));
  assign o_ready = !hazard;
  assign accept  = i_valid && o_ready;
  assign o_busy  = vld_p1 || vld_p2;

  always_comb begin
    cout_row = '0;
    for (int m = 0; m < NUM_MREGS; m++) begin
      for (int r = 0; r < VL; r++) begin
        if (idx_hit(mreg, m) && idx_hit(row, r)) begin
          for (int k = 0; k < VL; k++) begin
            cout_row[k*XLEN +: XLEN] = tile[m][r][k];
          end
        end
      end
    end
  end

  // Stage p1: products registered at accept; p2: products held for the tile update.
  always_ff @(posedge i_clk) begin
    mreg_p1 <= mreg;
    mreg_p2 <= mreg_p1;
    for (int i = 0; i < VL; i++) begin
      for (int j = 0; j < VL; j++) begin
        prod_p1[i][j] <= mul_lo(i_va[i*XLEN +: XLEN], i_vb[j*XLEN +: XLEN]);
        prod_p2[i][j] <= prod_p1[i][j];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      o_mvex_lqvld  <= 1'b0;
      o_mvex_lqexc  <= 1'b0;
      o_mvex_lqid   <= '0;
      o_mvex_lqdata <= '0;
    end else begin
      vld_p1       <= accept && op_opacc;
      vld_p2       <= vld_p1;
      o_mvex_lqvld <= accept && !op_opacc;
      if (accept && !op_opacc) begin
        o_mvex_lqexc  <= !legal;
        o_mvex_lqid   <= i_lqid;
        o_mvex_lqdata <= op_cout ? cout_row : '0;
      end
    end
  end

  // Stage p2 -> tile: accumulate; CIN and MZERO write the tile at their accept edge.
  always_ff @(posedge i_clk) begin
    for (int m = 0; m < NUM_MREGS; m++) begin
      for (int i = 0; i < VL; i++) begin
        for (int j = 0; j < VL; j++) begin
          if (!i_reset_n) begin
            tile[m][i][j] <= '0;
          end else begin
            if (vld_p2 && idx_hit(mreg_p2, m))
              tile[m][i][j] <= acc_wrap(tile[m][i][j], prod_p2[i][j]);
            if (accept && op_cin && idx_hit(mreg, m) && idx_hit(row, i))
              tile[m][i][j] <= i_vc[j*XLEN +: XLEN];
            if (accept && op_mzero && idx_hit(mreg, m))
              tile[m][i][j] <= '0;
          end
        end
      end
    end
  end

endmodule
